// File: rtl/lcd_rx_pkg.sv
// Shared types, instruction match constants and address folding
// for the HD44780-style 4-bit bus receiver.
package lcd_rx_pkg;

    localparam int BUF_DEPTH = 32;
    localparam int IDX_W     = 5;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    localparam logic [7:0] CLEAR          = 8'h01;
    localparam logic [7:0] HOME           = 8'h02;
    localparam logic [7:0] HOME_MASK      = 8'hFE;
    localparam logic [7:0] ENTRY          = 8'h04;
    localparam logic [7:0] ENTRY_MASK     = 8'hFC;
    localparam logic [7:0] FUNC_SET       = 8'h20;
    localparam logic [7:0] FUNC_SET_MASK  = 8'hE0;
    localparam logic [7:0] SET_DDRAM      = 8'h80;
    localparam logic [7:0] SET_DDRAM_MASK = 8'h80;

    typedef enum logic {
        CLR_IDLE,
        CLR_FILL
    } clr_state_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic       e;
        logic [3:0] nib;
    } bus_t;

    function automatic logic is_instr(
        input logic [7:0] b,
        input logic [7:0] val,
        input logic [7:0] mask
    );
        return (b & mask) == val;
    endfunction

    // Line select comes from the 0x40 bit, column from the low nibble.
    function automatic logic [IDX_W-1:0] fold_addr(input logic [6:0] a);
        logic line;
        line = (a & LINE1_BASE) != LINE0_BASE;
        return {line, a[3:0]};
    endfunction

endpackage

// File: rtl/lcd_nibble_capture.sv
// Bus synchroniser, E fall detection and nibble/byte assembly
// for both 8-bit init mode and 4-bit mode.
module lcd_nibble_capture
    import lcd_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs,
    input  logic       rw,
    input  logic       e,
    input  logic [3:0] d,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       nibble_mode,
    output logic       rd_seen
);

    bus_t [SYNC_STAGES-1:0] sync_q;
    bus_t       cur;
    logic       e_prev;
    logic       strb_q;
    logic       rs_q;
    logic       rw_q;
    logic [3:0] nib_q;
    logic       phase;
    logic [3:0] hi;
    logic [7:0] wide;

    assign cur  = sync_q[SYNC_STAGES-1];
    assign wide = {nib_q, 4'h0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= '{rs: rs, rw: rw, e: e, nib: d};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Registered strobe stage keeps the assembly logic off the sync path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_prev <= 1'b0;
            strb_q <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            nib_q  <= 4'h0;
        end else begin
            e_prev <= cur.e;
            strb_q <= e_prev & ~cur.e;
            rs_q   <= cur.rs;
            rw_q   <= cur.rw;
            nib_q  <= cur.nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid  <= 1'b0;
            byte_data   <= 8'h00;
            byte_rs     <= 1'b0;
            nibble_mode <= 1'b0;
            rd_seen     <= 1'b0;
            phase       <= 1'b0;
            hi          <= 4'h0;
        end else begin
            byte_valid <= 1'b0;
            if (strb_q) begin
                if (rw_q) begin
                    rd_seen <= 1'b1;
                end else if (!nibble_mode) begin
                    byte_valid <= 1'b1;
                    byte_data  <= wide;
                    byte_rs    <= rs_q;
                    if (is_instr(wide, FUNC_SET, FUNC_SET_MASK) && !wide[4]) begin
                        nibble_mode <= 1'b1;
                    end
                end else if (!phase) begin
                    hi    <= nib_q;
                    phase <= 1'b1;
                end else begin
                    byte_valid <= 1'b1;
                    byte_data  <= {hi, nib_q};
                    byte_rs    <= rs_q;
                    phase      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receive-side LCD bus model: executes display instructions
// against a 2x16 shadow buffer with a clear-fill sequencer.
module lcd_bus_receiver
    import lcd_rx_pkg::*;
#(
    parameter logic [7:0] CLEAR_CHAR  = 8'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic       lcd_4,
    input  logic       lcd_5,
    input  logic       lcd_6,
    input  logic       lcd_7,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       nibble_mode,
    output logic [4:0] cursor,
    output logic       busy,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       overrun,
    output logic       rd_seen
);

    clr_state_t state;
    clr_state_t state_n;
    logic [4:0] fill_idx;
    logic [4:0] fill_n;
    logic       inc;
    logic       exec;
    logic       do_clear;
    logic       do_data;
    logic       fill_done;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] mem [BUF_DEPTH];

    lcd_nibble_capture #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_capture (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs         (lcd_rs),
        .rw         (lcd_rw),
        .e          (lcd_e),
        .d          ({lcd_7, lcd_6, lcd_5, lcd_4}),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_rs    (byte_rs),
        .nibble_mode(nibble_mode),
        .rd_seen    (rd_seen)
    );

    assign exec      = byte_valid && (state == CLR_IDLE);
    assign do_clear  = exec && !byte_rs && (byte_data == CLEAR);
    assign do_data   = exec && byte_rs;
    assign fill_done = (state == CLR_FILL) && (fill_idx == 5'd31);
    // The clear byte cycle itself writes cell 0, so busy covers it too.
    assign busy      = (state == CLR_FILL) || do_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLR_IDLE;
            fill_idx <= 5'd0;
        end else begin
            state    <= state_n;
            fill_idx <= fill_n;
        end
    end

    always_comb begin
        state_n = state;
        fill_n  = fill_idx;
        unique case (state)
            CLR_IDLE: begin
                if (do_clear) begin
                    state_n = CLR_FILL;
                    fill_n  = 5'd1;
                end
            end
            CLR_FILL: begin
                fill_n = fill_idx + 5'd1;
                if (fill_idx == 5'd31) begin
                    state_n = CLR_IDLE;
                end
            end
            default: state_n = CLR_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cursor;
        wr_data = byte_data;
        unique case (1'b1)
            (state == CLR_FILL): begin
                wr_en   = 1'b1;
                wr_addr = fill_idx;
                wr_data = CLEAR_CHAR;
            end
            do_clear: begin
                wr_en   = 1'b1;
                wr_addr = 5'd0;
                wr_data = CLEAR_CHAR;
            end
            do_data: wr_en = 1'b1;
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor <= 5'd0;
            inc    <= 1'b1;
        end else if (fill_done) begin
            cursor <= 5'd0;
            inc    <= 1'b1;
        end else if (exec && !do_clear) begin
            if (byte_rs) begin
                cursor <= inc ? cursor + 5'd1 : cursor - 5'd1;
            end else if (is_instr(byte_data, HOME, HOME_MASK)) begin
                cursor <= 5'd0;
            end else if (is_instr(byte_data, ENTRY, ENTRY_MASK)) begin
                inc <= byte_data[1];
            end else if (is_instr(byte_data, SET_DDRAM, SET_DDRAM_MASK)) begin
                cursor <= fold_addr(byte_data[6:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (byte_valid && state == CLR_FILL) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= CLEAR_CHAR;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= CLEAR_CHAR;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with a transaction-level
// display model and a per-cycle byte stream / busy checker.
module tb_lcd_bus_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_4 = 1'b0;
    logic       lcd_5 = 1'b0;
    logic       lcd_6 = 1'b0;
    logic       lcd_7 = 1'b0;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       nibble_mode;
    logic [4:0] cursor;
    logic       busy;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       overrun;
    logic       rd_seen;

    lcd_bus_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_4      (lcd_4),
        .lcd_5      (lcd_5),
        .lcd_6      (lcd_6),
        .lcd_7      (lcd_7),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_rs    (byte_rs),
        .nibble_mode(nibble_mode),
        .cursor     (cursor),
        .busy       (busy),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .overrun    (overrun),
        .rd_seen    (rd_seen)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         due;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   clr_start = -1000;
    exp_t q[$];

    logic [7:0] m_buf [32];
    logic [4:0] m_cur;
    logic       m_inc;
    logic       m_mode;
    logic       m_phase;
    logic [3:0] m_hi;
    logic       m_overrun;
    logic       m_rd_seen;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_cur = 5'd0;
        m_inc = 1'b1;
        m_mode = 1'b0;
        m_phase = 1'b0;
        m_hi = 4'h0;
        m_overrun = 1'b0;
        m_rd_seen = 1'b0;
        clr_start = -1000;
        q.delete();
    endtask

    task automatic model_exec(input logic [7:0] b, input logic rs, input int due);
        exp_t e;
        e.d = b;
        e.rs = rs;
        e.due = due;
        q.push_back(e);
        if (due > clr_start && due <= clr_start + 31) begin
            m_overrun = 1'b1;
        end else if (rs) begin
            m_buf[m_cur] = b;
            m_cur = m_inc ? m_cur + 5'd1 : m_cur - 5'd1;
        end else if (b == 8'h01) begin
            clr_start = due;
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            m_cur = 5'd0;
            m_inc = 1'b1;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_cur = 5'd0;
        end else if (b[7:2] == 6'b000001) begin
            m_inc = b[1];
        end else if (b[7]) begin
            m_cur = {b[6], b[3:0]};
        end
    endtask

    task automatic model_strobe(input logic rs, input logic rw,
                                input logic [3:0] n, input int fall);
        logic [7:0] b;
        if (rw) begin
            m_rd_seen = 1'b1;
        end else if (!m_mode) begin
            b = {n, 4'h0};
            model_exec(b, rs, fall + 4);
            if (b[7:5] == 3'b001 && !b[4]) m_mode = 1'b1;
        end else if (!m_phase) begin
            m_hi = n;
            m_phase = 1'b1;
        end else begin
            m_phase = 1'b0;
            model_exec({m_hi, n}, rs, fall + 4);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] n);
        int fall;
        lcd_rs = rs;
        lcd_rw = rw;
        {lcd_7, lcd_6, lcd_5, lcd_4} = n;
        repeat (3) @(posedge clk);
        #1 lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        fall = cyc;
        model_strobe(rs, rw, n, fall);
        repeat (6) @(posedge clk);
        #1;
        chk("nibble_mode", nibble_mode, m_mode);
        chk("rd_seen", rd_seen, m_rd_seen);
        if (cyc > clr_start + 32) chk("cursor", cursor, m_cur);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        strobe(rs, 1'b0, b[7:4]);
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        rd_addr = a[4:0];
        @(posedge clk);
        #1 v = rd_data;
    endtask

    task automatic check_all();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            chk($sformatf("buf%0d", i), v, m_buf[i]);
        end
    endtask

    // Byte stream, latency and busy window are checked every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, (cyc >= clr_start && cyc <= clr_start + 31));
            if (busy) busy_cnt++;
            if (byte_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte got=%0h exp=none", byte_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("byte_cycle", cyc, e.due);
                    chk("byte_data", byte_data, e.d);
                    chk("byte_rs", byte_rs, e.rs);
                end
            end else if (q.size() > 0 && q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL byte_timeout got=none exp=%0h", q[0].d);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        model_reset();
        #35;
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_byte_data", byte_data, 8'h00);
        chk("rst_mode", nibble_mode, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_data", rd_data, 8'h20);
        @(posedge clk);
        #1 rst_n = 1'b1;

        strobe(1'b0, 1'b0, 4'h3);
        strobe(1'b0, 1'b0, 4'h3);
        strobe(1'b0, 1'b0, 4'h3);
        chk("mode_after_0x30", nibble_mode, 1'b0);
        strobe(1'b0, 1'b0, 4'h2);
        chk("mode_lit", nibble_mode, 1'b1);
        send_byte(1'b0, 8'h28);
        chk("fs_data_lit", byte_data, 8'h28);
        chk("fs_rs_lit", byte_rs, 1'b0);

        send_byte(1'b1, 8'h48);
        chk("h_data_lit", byte_data, 8'h48);
        chk("h_cursor_lit", cursor, 5'd1);
        rd(0, v);
        chk("h_buf0_lit", v, 8'h48);

        send_byte(1'b0, 8'hC0);
        chk("c0_cursor_lit", cursor, 5'd16);
        send_byte(1'b1, 8'h41);
        chk("a_cursor_lit", cursor, 5'd17);
        rd(16, v);
        chk("a_buf16_lit", v, 8'h41);
        send_byte(1'b0, 8'h8F);
        send_byte(1'b1, 8'h42);
        chk("b_cursor_lit", cursor, 5'd16);
        rd(15, v);
        chk("b_buf15_lit", v, 8'h42);
        check_all();

        busy_cnt = 0;
        send_byte(1'b0, 8'h01);
        send_byte(1'b1, 8'h55);
        repeat (40) @(posedge clk);
        #1;
        chk("busy_len_lit", busy_cnt, 32);
        chk("overrun_lit", overrun, 1'b1);
        chk("clr_cursor_lit", cursor, 5'd0);
        check_all();

        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'h02);
        rd_addr = 5'd0;
        fork
            send_byte(1'b1, 8'h5A);
            begin
                for (int k = 0; k < 80 && !byte_valid; k++) @(negedge clk);
                if (!byte_valid) chk("rbw_wait", 1'b0, 1'b1);
                @(posedge clk);
                #1 chk("rbw_old_lit", rd_data, 8'h20);
                @(posedge clk);
                #1 chk("rbw_new_lit", rd_data, 8'h5A);
            end
        join
        chk("wrap_cursor_lit", cursor, 5'd31);

        strobe(1'b1, 1'b0, 4'h6);
        strobe(1'b0, 1'b1, 4'hF);
        strobe(1'b1, 1'b0, 4'h1);
        chk("rd_seen_lit", rd_seen, 1'b1);
        chk("rw_data_lit", byte_data, 8'h61);
        rd(31, v);
        chk("rw_buf31_lit", v, 8'h61);

        strobe(1'b0, 1'b0, 4'h3);
        #3 rst_n = 1'b0;
        #2;
        model_reset();
        chk("mrst_byte_valid", byte_valid, 1'b0);
        chk("mrst_byte_data", byte_data, 8'h00);
        chk("mrst_byte_rs", byte_rs, 1'b0);
        chk("mrst_mode", nibble_mode, 1'b0);
        chk("mrst_cursor", cursor, 5'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_rd_seen", rd_seen, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mrst_rd31_lit", rd_data, 8'h20);
        strobe(1'b0, 1'b0, 4'h2);
        chk("mrst_fs_data_lit", byte_data, 8'h20);
        chk("mrst_fs_mode_lit", nibble_mode, 1'b1);
        check_all();

        repeat (10) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending_bytes got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
